// File: rtl/seg_pkg.sv
// Shared constants, decode table and state type for the seven-segment scan controller.
// Latency: combinational helpers only.
// Backpressure: not applicable.
package seg_pkg;

    // All segments dark; the segment bus is active-low.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low gfedcba patterns for hex digits 0..F.
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic {
        BLANK = 1'b0,
        SCAN  = 1'b1
    } scan_state_e;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        return SEG_LUT[nib];
    endfunction

endpackage

// File: rtl/seg_scan_tick.sv
// Digit-slot prescaler and slot index counter; tick marks the last cycle of a slot.
// Latency: tick/last are combinational on the registered count and index.
// Backpressure: none; counting freezes whenever run_i is low.
module seg_scan_tick #(
    parameter int DIGITS = 8,
    parameter int DIV    = 50000,
    localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1,
    localparam int CW    = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          run_i,
    output logic          tick_o,
    output logic [IW-1:0] idx_o,
    output logic          last_o
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;

    assign tick_o = run_i && (cnt_q == CW'(DIV - 1));
    assign last_o = (idx_q == IW'(DIGITS - 1));
    assign idx_o  = idx_q;

    // Next count/index: hold while not running, wrap the slot index at the last digit.
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (run_i) begin
            if (tick_o) begin
                cnt_d = '0;
                idx_d = last_o ? '0 : idx_q + IW'(1);
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Prescaler and index registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode 7-seg scan controller with frame-aligned display updates.
// Latency: outputs registered one cycle behind slot index/state; new words land at the next frame boundary.
// Backpressure: upd_ready drops while a word is pending and rises the cycle after it is applied.
// Optional leading-zero suppression: define SEG_SCAN_LZ_SUPPRESS_EN.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS = 8,
    parameter int DIV    = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  upd_valid,
    input  logic [4*DIGITS-1:0]   upd_data,
    output logic                  upd_ready,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_mask,
    output logic [6:0]            seg_o,
    output logic                  dp_o,
    output logic [DIGITS-1:0]     an_o,
    output logic                  frame_done
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    scan_state_e           state_q;
    logic [4*DIGITS-1:0]   pend_q;
    logic                  pend_v_q;
    logic [4*DIGITS-1:0]   disp_q;
    logic [DIGITS-1:0]     an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic                  frame_done_q;

    logic                  run;
    logic                  tick;
    logic                  last;
    logic [IW-1:0]         idx;
    logic                  boundary;
    logic                  lz_show;
    logic                  show;
    logic [DIGITS-1:0]     onehot;
    logic [3:0]            nib;

    assign run      = (state_q == SCAN);
    assign boundary = tick && last;

    seg_scan_tick #(
        .DIGITS (DIGITS),
        .DIV    (DIV)
    ) u_tick (
        .clk_i  (clk),
        .rst_i  (rst),
        .run_i  (run),
        .tick_o (tick),
        .idx_o  (idx),
        .last_o (last)
    );

`ifdef SEG_SCAN_LZ_SUPPRESS_EN
    logic [IW-1:0] lead;

    // Highest nonzero nibble of the shown word; digit 0 stays lit even for an all-zero word.
    always_comb begin
        lead = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (disp_q[4*i +: 4] != 4'h0) begin
                lead = IW'(i);
            end
        end
    end

    assign lz_show = (idx <= lead);
`else
    assign lz_show = 1'b1;
`endif

    assign show   = run && !blank_mask[idx] && lz_show;
    assign onehot = DIGITS'(1) << idx;
    assign nib    = disp_q[4*idx +: 4];

    // Next output drive for the current slot; dark whenever the slot is not shown.
    always_comb begin
        an_d  = '1;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (show) begin
            an_d  = ~onehot;
            seg_d = seg_decode(nib);
            dp_d  = ~dp_in[idx];
        end
    end

    // Scan state, update handshake, shadow/display words and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= BLANK;
            pend_q       <= '0;
            pend_v_q     <= 1'b0;
            disp_q       <= '0;
            an_q         <= '1;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q <= en ? SCAN : BLANK;
            // Accept and transfer are exclusive: accept needs an empty shadow, transfer a full one.
            if (upd_valid && !pend_v_q) begin
                pend_q   <= upd_data;
                pend_v_q <= 1'b1;
            end else if (boundary && pend_v_q) begin
                disp_q   <= pend_q;
                pend_v_q <= 1'b0;
            end
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= boundary;
        end
    end

    assign upd_ready  = ~pend_v_q;
    assign an_o       = an_q;
    assign seg_o      = seg_q;
    assign dp_o       = dp_q;
    assign frame_done = frame_done_q;

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a bank of common-anode seven-segment digits that share one segment bus. It holds a display word of DIGITS hex nibbles and steps a one-hot active-low anode select at a prescaled rate. Each slot's nibble goes through the team's standard hex-to-7-segment decode. New display words are accepted through a valid/ready handshake and applied only at frame boundaries, so a frame never shows a mix of old and new values.

Parameters:
DIGITS, 8, number of multiplexed digits (1..16)
DIV, 50000, clk cycles per digit slot (>=1)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
en  input  1  scan enable; 0 blanks the display
upd_valid  input  1  new display word offered
upd_data  input  4*DIGITS  nibble i = digit i (digit 0 = LSBs)
upd_ready  output  1  controller can accept upd_data
dp_in  input  DIGITS  decimal point request per digit, 1 = lit
blank_mask  input  DIGITS  1 = force digit i dark
seg_o  output  7  segments g..a, active-low (bit0=a)
dp_o  output  1  decimal point, active-low
an_o  output  DIGITS  anode select, one-hot active-low
frame_done  output  1  one-cycle pulse at end of each full scan

Behaviour:
- Reset: cnt=0, idx=0, disp=0, pend_v=0, state=BLANK. Outputs: an_o all 1, seg_o=7'h7F, dp_o=1, upd_ready=1, frame_done=0. Reset mid-frame discards any pending word.
- Prescaler: cnt counts 0..DIV-1 while state=SCAN. tick = (cnt==DIV-1). On tick, cnt->0 and idx->idx+1, wrapping DIGITS-1->0. With DIV=1, tick fires every SCAN cycle. With DIGITS=1, idx stays 0.
- States:
  - BLANK: entered from reset or when en=0. cnt and idx hold.
  - SCAN: entered the cycle after en=1 is sampled. Resumes at the held idx/cnt.
  - SCAN->BLANK the cycle after en=0 is sampled.
- Output register (1-cycle latency from idx/state):
  - In SCAN with !blank_mask[idx]: an_o=~(1<<idx), seg_o=decode(disp[4*idx+:4]), dp_o=~dp_in[idx].
  - Otherwise: an_o all 1, seg_o=7'h7F, dp_o=1.
  - dp_in and blank_mask are sampled live, with no shadowing.
- Decode table (active-low gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Update handshake:
  - upd_ready = ~pend_v.
  - Accept when upd_valid && upd_ready: pend<=upd_data, pend_v<=1.
  - At a frame boundary (tick && idx==DIGITS-1): if pend_v, then disp<=pend and pend_v<=0, so upd_ready rises next cycle.
  - A word accepted in the boundary cycle itself (pend_v was 0) is applied at the next boundary.
  - upd_data must remain stable while upd_valid=1 && upd_ready=0.
  - Worst-case apply latency: one frame (DIGITS*DIV cycles) plus 1 cycle.
  - Handshake is accepted in BLANK as well, but words transfer only on SCAN boundaries.
- frame_done: registered, high for exactly one cycle following each frame boundary tick.
- Simultaneous en falling and tick: the tick takes effect (idx advances, transfer occurs), then the block enters BLANK.

Optional Feature:
SEG_SCAN_LZ_SUPPRESS_EN
- Defined: leading-zero suppression. Every digit above the highest nonzero nibble of disp is treated as blanked (an_o high), and its dp_in is ignored. Digit 0 is always shown, so disp=0 displays a single "0".
- Undefined: all digits are shown subject only to blank_mask.
- The lead-position computation is combinational on disp and does not change output latency.

Decomposition:
- Package seg_pkg holds:
  - SEG_BLANK constant (7'h7F)
  - 16-entry active-low decode constant array
  - seg_decode function
  - state enum {BLANK, SCAN}
- One natural sub-module: seg_scan_tick, containing the prescaler and the idx wrap counter. It produces tick, idx, and last (idx==DIGITS-1). The parent holds the handshake, shadow registers, and output registers.

Test Plan:
- Reset/idle (DIGITS=4, DIV=4): assert rst 3 cycles with en=0 -> an_o=4'hF, seg_o=7'h7F, dp_o=1, upd_ready=1 throughout. en=0 for 20 cycles -> outputs unchanged.
- Scan order: upd_data=16'h3A90, en=1 -> after the first frame boundary, an_o cycles E,D,B,7 every 4 cycles. seg_o is 1000000, 0010000, 0001000, 0110000 respectively. frame_done pulses every 16 cycles.
- Tear-free update: offer 16'h1234 mid-frame while showing 16'h3A90 -> accepted immediately, upd_ready=0. A second offer 16'h5678 is stalled until the boundary. Digits switch to 1234 only after frame_done, never mixed within a frame.
- Blank/dp: blank_mask=4'b0100, dp_in=4'b0001 -> slot 2 has an_o all 1 and seg_o=7'h7F. dp_o=0 only during the slot-0 window.
- Enable/reset mid-frame: drop en at idx=2, raise it 10 cycles later -> blank within 1 cycle, resume at idx=2 with the same cnt. Assert rst mid-frame with a pending word -> pending is lost, disp=0, idx=0.
- SEG_SCAN_LZ_SUPPRESS_EN defined: disp=16'h0050 -> digits 3 and 2 dark, digit 1 shows "5", digit 0 shows "0". disp=0 -> only digit 0 lit, showing "0".
